// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI4 INCR-burst SRAM slave.
//   state_e          : transaction FSM states
//   AXI_RESP_*       : AXI response encodings used by B and R channels
//   beat_addr_incr() : next-beat byte address (wraps at the caller's width)
package axi_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Wide enough for any practical byte address; callers truncate back to
  // their own ADDR_WIDTH, which gives the modulo-2^ADDR_WIDTH wrap.
  localparam int ADDR_CALC_W = 64;

  function automatic logic [ADDR_CALC_W-1:0] beat_addr_incr(
    input logic [ADDR_CALC_W-1:0] addr_i,
    input logic [ADDR_CALC_W-1:0] step_i
  );
    return addr_i + step_i;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables.
//   clk_i            : clock
//   we_i/widx_i      : write enable and word index
//   wdata_i/wstrb_i  : write data and byte strobes
//   re_i/ridx_i      : read enable and word index
//   rdata_o          : registered read data, holds its value while re_i=0
// The array and read register are data only and are never reset.
module axi_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   widx_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   ridx_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_burst_sram_slave.sv
// AXI4 INCR-burst slave in front of an internal byte-strobed memory.
// One transaction at a time; every beat is range-checked against
// [BASE_ADDR, BASE_ADDR + DEPTH*DATA_WIDTH/8) and answers SLVERR when outside.
// Ports:
//   wb_clk_i, wb_rst_ni          : clock, synchronous active-low reset
//   axi_aw*  (valid/ready/addr/len)           : write address channel
//   axi_w*   (valid/ready/data/strb/last)     : write data channel
//   axi_b*   (valid/ready/resp)               : write response channel
//   axi_ar*  (valid/ready/addr/len)           : read address channel
//   axi_r*   (valid/ready/data/resp/last)     : read data channel
// Build option:
//   AXI_SRAM_RR_ARB_EN : round-robin AW/AR arbitration in IDLE
//                        (default: write always wins on contention).
module axi_burst_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
  input  logic [7:0]              axi_awlen_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  output logic [1:0]              axi_bresp_o,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
  input  logic [7:0]              axi_arlen_i,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic [DATA_WIDTH-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    awready_q, awready_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rng_q, rng_d;
`ifdef AXI_SRAM_RR_ARB_EN
  logic                    last_wr_q, last_wr_d;
`endif

  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    aw_hs, ar_hs, grant_wr;
  logic                    mem_we, mem_re;
  logic [IDX_W-1:0]        mem_widx, mem_ridx;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    // Addresses below BASE_ADDR wrap to huge offsets and fail this test too.
    return (off >> OFFS) < ADDR_WIDTH'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[OFFS +: IDX_W];
  endfunction

  assign addr_next = ADDR_WIDTH'(beat_addr_incr(ADDR_CALC_W'(addr_q), ADDR_CALC_W'(BYTES)));
  assign aw_hs     = axi_awvalid_i && awready_q;
  assign ar_hs     = axi_arvalid_i && arready_q;

`ifdef AXI_SRAM_RR_ARB_EN
  assign grant_wr = axi_awvalid_i && (!axi_arvalid_i || !last_wr_q);
`else
  assign grant_wr = axi_awvalid_i;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rng_d     = rng_q;
`ifdef AXI_SRAM_RR_ARB_EN
    last_wr_d = last_wr_q;
`endif
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_widx  = word_idx(addr_q);
    mem_ridx  = word_idx(addr_next);

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          addr_d  = axi_awaddr_i;
          len_d   = axi_awlen_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_WDATA;
        end else if (ar_hs) begin
          addr_d   = axi_araddr_i;
          len_d    = axi_arlen_i;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_RDATA;
          // Launch beat 0 now so rvalid can rise on the next cycle.
          mem_re   = 1'b1;
          mem_ridx = word_idx(axi_araddr_i);
          rng_d    = in_range(axi_araddr_i);
          rvalid_d = 1'b1;
        end else begin
          // Readies are re-arbitrated every idle cycle, so only one channel
          // is ever offered a handshake and a dropped valid cannot wedge us.
          awready_d = grant_wr;
          arready_d = !grant_wr && axi_arvalid_i;
`ifdef AXI_SRAM_RR_ARB_EN
          if (axi_awvalid_i || axi_arvalid_i) begin
            last_wr_d = grant_wr;
          end
`endif
        end
      end

      ST_WDATA: begin
        if (axi_wvalid_i) begin
          mem_we = in_range(addr_q) && wb_rst_ni;
          if (!in_range(addr_q) || (axi_wlast_i != (cnt_q == len_q))) begin
            err_d = 1'b1;
          end
          if (axi_wlast_i || (cnt_q == len_q)) begin
            state_d = ST_WRESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end

      ST_WRESP: begin
        if (axi_bready_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_RDATA: begin
        if (rvalid_q && axi_rready_i) begin
          if (cnt_q == len_q) begin
            rvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            // Prefetch the next beat during this handshake: no bubble.
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_next;
            mem_re = 1'b1;
            rng_d  = in_range(addr_next);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rng_q     <= 1'b0;
`ifdef AXI_SRAM_RR_ARB_EN
      last_wr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rng_q     <= rng_d;
`ifdef AXI_SRAM_RR_ARB_EN
      last_wr_q <= last_wr_d;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  axi_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .we_i    (mem_we),
    .widx_i  (mem_widx),
    .wdata_i (axi_wdata_i),
    .wstrb_i (axi_wstrb_i),
    .re_i    (mem_re),
    .ridx_i  (mem_ridx),
    .rdata_o (mem_rdata)
  );

  assign axi_awready_o = awready_q;
  assign axi_arready_o = arready_q;
  assign axi_wready_o  = (state_q == ST_WDATA);
  assign axi_bvalid_o  = (state_q == ST_WRESP);
  assign axi_bresp_o   = ((state_q == ST_WRESP) && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rdata_o   = (rvalid_q && rng_q) ? mem_rdata : '0;
  assign axi_rresp_o   = (rvalid_q && !rng_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_rlast_o   = rvalid_q && (cnt_q == len_q);

endmodule
